// File: rtl/square_anim.sv
`default_nettype none
// ============================================================================
// Module      : square_anim
// Description : Draws a solid square that bounces around the active display
//               area. Position advances once per frame in the vertical
//               blanking interval. Each frame in which the square hits an
//               edge advances the square's colour and a bounce counter.
//               Colour and timing outputs are registered, one cycle after
//               the screen position inputs.
// Ports       : clk_pix            pixel clock (only clock)
//               rst_n              asynchronous active-low reset
//               sx, sy             current screen position
//               hsync, vsync, de   timing syncs and data enable
//               move_en            enables per-frame motion
//               o_red/green/blue   pixel colour (0 outside active area)
//               o_hsync/vsync/de   syncs and de, aligned with colour
//               bounce_cnt         frames in which a bounce occurred (wraps)
// Revision    : 1.0  initial release
// ============================================================================
module square_anim #(
    parameter int CORDW  = 11,
    parameter int H_RES  = 1280,
    parameter int V_RES  = 720,
    parameter int Q_SIZE = 64,
    parameter int SPEED  = 4,
    parameter int CHANW  = 8
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    input  logic             move_en,
    output logic [CHANW-1:0] o_red,
    output logic [CHANW-1:0] o_green,
    output logic [CHANW-1:0] o_blue,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [15:0]      bounce_cnt
);

    // Background green is 0x88 placed in the top bits of the channel.
    function automatic logic [CHANW-1:0] f_bg_green();
        logic [7:0]       v;
        logic [CHANW-1:0] g;
        v = 8'h88;
        g = '0;
        for (int i = 0; i < CHANW && i < 8; i++) begin
            g[CHANW-1-i] = v[7-i];
        end
        return g;
    endfunction

    localparam logic [CHANW-1:0] c_BG_G    = f_bg_green();
    localparam logic [CORDW-1:0] c_V_RES   = CORDW'(V_RES);
    localparam logic [CORDW-1:0] c_SPEED   = CORDW'(SPEED);
    localparam logic [CORDW-1:0] c_X_MAX   = CORDW'(H_RES - Q_SIZE);
    localparam logic [CORDW-1:0] c_Y_MAX   = CORDW'(V_RES - Q_SIZE);
    localparam logic [CORDW:0]   c_Q_SIZE  = (CORDW+1)'(Q_SIZE);

    logic [CORDW-1:0] r_qx, r_qy;
    logic             r_dx, r_dy;
    logic [1:0]       r_colr;

    logic             w_tick;
    logic [CORDW-1:0] w_qx_nx, w_qy_nx;
    logic             w_dx_nx, w_dy_nx;
    logic             w_hit_x, w_hit_y;
    logic             w_q_draw;
    logic [CHANW-1:0] w_red, w_green, w_blue;

    // One axis step. Edge tests are done one bit wider than the coordinate
    // so that pos + SPEED can never wrap and fake a miss.
    function automatic void f_step(
        input  logic [CORDW-1:0] pos,
        input  logic             dir,
        input  logic [CORDW-1:0] lim,
        output logic [CORDW-1:0] npos,
        output logic             ndir,
        output logic             hit
    );
        npos = pos;
        ndir = dir;
        hit  = 1'b0;
        if (dir) begin
            if ({1'b0, pos} + {1'b0, c_SPEED} >= {1'b0, lim}) begin
                npos = lim;
                ndir = 1'b0;
                hit  = 1'b1;
            end else begin
                npos = pos + c_SPEED;
            end
        end else begin
            if ({1'b0, pos} <= {1'b0, c_SPEED}) begin
                npos = '0;
                ndir = 1'b1;
                hit  = 1'b1;
            end else begin
                npos = pos - c_SPEED;
            end
        end
    endfunction

    // First blanking line, first pixel: happens exactly once per frame.
    assign w_tick = (sy == c_V_RES) && (sx == '0);

    always_comb begin
        w_qx_nx = r_qx;
        w_dx_nx = r_dx;
        w_hit_x = 1'b0;
        w_qy_nx = r_qy;
        w_dy_nx = r_dy;
        w_hit_y = 1'b0;
        f_step(r_qx, r_dx, c_X_MAX, w_qx_nx, w_dx_nx, w_hit_x);
        f_step(r_qy, r_dy, c_Y_MAX, w_qy_nx, w_dy_nx, w_hit_y);
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_qx       <= '0;
            r_qy       <= '0;
            r_dx       <= 1'b1;
            r_dy       <= 1'b1;
            r_colr     <= 2'd0;
            bounce_cnt <= 16'd0;
        end else if (w_tick && move_en) begin
            r_qx <= w_qx_nx;
            r_qy <= w_qy_nx;
            r_dx <= w_dx_nx;
            r_dy <= w_dy_nx;
            // A corner hit clamps both axes but still counts as one bounce.
            if (w_hit_x || w_hit_y) begin
                bounce_cnt <= bounce_cnt + 16'd1;
                r_colr     <= r_colr + 2'd1;
            end
        end
    end

    assign w_q_draw = ({1'b0, sx} >= {1'b0, r_qx}) &&
                      ({1'b0, sx} <  {1'b0, r_qx} + c_Q_SIZE) &&
                      ({1'b0, sy} >= {1'b0, r_qy}) &&
                      ({1'b0, sy} <  {1'b0, r_qy} + c_Q_SIZE);

    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (w_q_draw) begin
            case (r_colr)
                2'd0: begin
                    w_red   = '1;
                    w_green = '1;
                    w_blue  = '1;
                end
                2'd1: w_red = '1;
                2'd2: w_green = '1;
                default: begin
                    w_red   = '1;
                    w_green = '1;
                end
            endcase
        end else begin
            w_green = c_BG_G;
            w_blue  = '1;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
        end else begin
            o_red   <= de ? w_red   : '0;
            o_green <= de ? w_green : '0;
            o_blue  <= de ? w_blue  : '0;
            o_hsync <= hsync;
            o_vsync <= vsync;
            o_de    <= de;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_square_anim.sv
`default_nettype none
// ============================================================================
// Module      : tb_square_anim
// Description : Self-checking bench for square_anim. Three instances cover
//               the default geometry, a 16x16 screen and an 8x8 screen where
//               every frame bounces. Pixel expectations go through a queue
//               and are compared against the registered outputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_square_anim;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0][10:0] sx_a, sy_a;
    logic [2:0]       hs_a, vs_a, de_a, men_a;
    wire  [2:0][7:0]  r_a, g_a, b_a;
    wire  [2:0]       ohs_a, ovs_a, ode_a;
    wire  [2:0][15:0] bc_a;

    square_anim u_dut0 (
        .clk_pix(clk), .rst_n(rst_n), .sx(sx_a[0]), .sy(sy_a[0]),
        .hsync(hs_a[0]), .vsync(vs_a[0]), .de(de_a[0]), .move_en(men_a[0]),
        .o_red(r_a[0]), .o_green(g_a[0]), .o_blue(b_a[0]),
        .o_hsync(ohs_a[0]), .o_vsync(ovs_a[0]), .o_de(ode_a[0]), .bounce_cnt(bc_a[0])
    );
    square_anim #(.H_RES(16), .V_RES(16), .Q_SIZE(4), .SPEED(4)) u_dut1 (
        .clk_pix(clk), .rst_n(rst_n), .sx(sx_a[1]), .sy(sy_a[1]),
        .hsync(hs_a[1]), .vsync(vs_a[1]), .de(de_a[1]), .move_en(men_a[1]),
        .o_red(r_a[1]), .o_green(g_a[1]), .o_blue(b_a[1]),
        .o_hsync(ohs_a[1]), .o_vsync(ovs_a[1]), .o_de(ode_a[1]), .bounce_cnt(bc_a[1])
    );
    square_anim #(.H_RES(8), .V_RES(8), .Q_SIZE(4), .SPEED(4)) u_dut2 (
        .clk_pix(clk), .rst_n(rst_n), .sx(sx_a[2]), .sy(sy_a[2]),
        .hsync(hs_a[2]), .vsync(vs_a[2]), .de(de_a[2]), .move_en(men_a[2]),
        .o_red(r_a[2]), .o_green(g_a[2]), .o_blue(b_a[2]),
        .o_hsync(ohs_a[2]), .o_vsync(ovs_a[2]), .o_de(ode_a[2]), .bounce_cnt(bc_a[2])
    );

    int HR[3] = '{1280, 16, 8};
    int VR[3] = '{720, 16, 8};
    int QS[3] = '{64, 4, 4};
    int SP[3] = '{4, 4, 4};

    // Reference model state per instance.
    int mqx[3], mqy[3], mdx[3], mdy[3], mcol[3], mbc[3];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          k;
        logic [26:0] exp;
        string       nm;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int          x, y;
        logic        d, h, v;
        logic [23:0] rgb;
        string       nm;
    } vec_t;
    vec_t vecs[10];

    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] BG     = 24'h0088FF;

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            mqx[j] = 0; mqy[j] = 0; mdx[j] = 1; mdy[j] = 1; mcol[j] = 0; mbc[j] = 0;
        end
    endtask

    task automatic model_tick(input int k);
        bit b;
        b = 0;
        if (mdx[k] == 1) begin
            if (mqx[k] + SP[k] >= HR[k] - QS[k]) begin mqx[k] = HR[k] - QS[k]; mdx[k] = 0; b = 1; end
            else mqx[k] = mqx[k] + SP[k];
        end else begin
            if (mqx[k] <= SP[k]) begin mqx[k] = 0; mdx[k] = 1; b = 1; end
            else mqx[k] = mqx[k] - SP[k];
        end
        if (mdy[k] == 1) begin
            if (mqy[k] + SP[k] >= VR[k] - QS[k]) begin mqy[k] = VR[k] - QS[k]; mdy[k] = 0; b = 1; end
            else mqy[k] = mqy[k] + SP[k];
        end else begin
            if (mqy[k] <= SP[k]) begin mqy[k] = 0; mdy[k] = 1; b = 1; end
            else mqy[k] = mqy[k] - SP[k];
        end
        if (b) begin
            mbc[k]  = (mbc[k] + 1) % 65536;
            mcol[k] = (mcol[k] + 1) % 4;
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int k, input int x, input int y, input logic d);
        if (!d) return 24'h0;
        if (x >= mqx[k] && x < mqx[k] + QS[k] && y >= mqy[k] && y < mqy[k] + QS[k]) begin
            case (mcol[k])
                0: return WHITE;
                1: return RED;
                2: return GREEN;
                default: return YELLOW;
            endcase
        end
        return BG;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic idle_all();
        for (int j = 0; j < 3; j++) begin
            sx_a[j] = 11'd1; sy_a[j] = 11'd0;
            hs_a[j] = 1'b0; vs_a[j] = 1'b0; de_a[j] = 1'b0; men_a[j] = 1'b0;
        end
    endtask

    // Drive one pixel on instance k, queue its expected output, then compare
    // the registered result one cycle later.
    task automatic cycle(input int k, input int x, input int y, input logic d,
                         input logic h, input logic v, input logic m,
                         input logic [23:0] rgb, input string nm);
        sb_t e;
        logic [26:0] act;
        @(negedge clk);
        idle_all();
        sx_a[k] = 11'(x); sy_a[k] = 11'(y);
        de_a[k] = d; hs_a[k] = h; vs_a[k] = v; men_a[k] = m;
        e.k = k; e.exp = {rgb, h, v, d}; e.nm = nm;
        sbq.push_back(e);
        if (x == 0 && y == VR[k] && m) model_tick(k);
        @(posedge clk);
        #1;
        e   = sbq.pop_front();
        act = {r_a[e.k], g_a[e.k], b_a[e.k], ohs_a[e.k], ovs_a[e.k], ode_a[e.k]};
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s (dut%0d): got %h, required %h", e.nm, e.k, act, e.exp);
        end
    endtask

    task automatic tick(input int k, input logic m);
        cycle(k, 0, VR[k], 1'b0, 1'b0, 1'b1, m, 24'h0, "tick");
    endtask

    task automatic pix(input int k, input int x, input int y, input logic [23:0] rgb, input string nm);
        cycle(k, x, y, 1'b1, 1'b0, 1'b0, 1'b0, rgb, nm);
    endtask

    initial begin
        vecs[0] = '{0,    0,   1, 0, 0, WHITE, "origin white"};
        vecs[1] = '{63,   63,  1, 0, 0, WHITE, "square inner corner"};
        vecs[2] = '{64,   0,   1, 0, 0, BG,    "right of square"};
        vecs[3] = '{0,    64,  1, 0, 0, BG,    "below square"};
        vecs[4] = '{63,   64,  1, 0, 0, BG,    "below corner"};
        vecs[5] = '{640,  360, 1, 0, 0, BG,    "centre bg"};
        vecs[6] = '{1279, 719, 1, 0, 0, BG,    "last active pixel"};
        vecs[7] = '{10,   10,  0, 1, 0, 24'h0, "blank inside square"};
        vecs[8] = '{1300, 5,   0, 1, 0, 24'h0, "hsync region"};
        vecs[9] = '{5,    740, 0, 0, 1, 24'h0, "vsync region"};

        model_reset();
        idle_all();
        rst_n = 1'b0;
        sx_a[0] = 11'd0; sy_a[0] = 11'd0; de_a[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rgb", {r_a[0], g_a[0], b_a[0]}, 0);
        chk("reset de", ode_a[0], 0);
        chk("reset bounce", bc_a[0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame after reset, default geometry.
        for (int i = 0; i < 10; i++)
            cycle(0, vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].h, vecs[i].v, 1'b0, vecs[i].rgb, vecs[i].nm);

        // 164 frames: y clamps at 656 exactly on the last one.
        for (int i = 0; i < 164; i++) tick(0, 1'b1);
        chk("bounce after 164", bc_a[0], 1);
        pix(0, 656, 656, RED, "red square tl");
        pix(0, 655, 656, BG,  "left of red square");
        pix(0, 719, 719, RED, "red square br");
        pix(0, 720, 719, BG,  "right of red square");
        pix(0, 656, 655, BG,  "above red square");

        // Motion held off, then resumes.
        for (int i = 0; i < 10; i++) tick(0, 1'b0);
        chk("bounce held", bc_a[0], 1);
        pix(0, 656, 656, RED, "held position");
        pix(0, 655, 656, BG,  "held left edge");
        tick(0, 1'b1);
        pix(0, 660, 652, RED, "resumed tl");
        pix(0, 659, 652, BG,  "resumed left");
        pix(0, 723, 715, RED, "resumed br");
        pix(0, 724, 715, BG,  "resumed right");
        pix(0, 660, 651, BG,  "resumed above");
        chk("bounce resumed", bc_a[0], 1);

        // Small screen: corner hit counted once, then return to origin.
        for (int i = 0; i < 3; i++) tick(1, 1'b1);
        chk("corner bounce", bc_a[1], 1);
        pix(1, 12, 12, RED, "corner square");
        pix(1, 11, 12, BG,  "corner left");
        pix(1, 12, 11, BG,  "corner above");
        pix(1, 15, 15, RED, "corner br");
        for (int i = 0; i < 3; i++) tick(1, 1'b1);
        chk("origin bounce", bc_a[1], 2);
        cycle(1, 1, 16, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, "non-tick sx=1");
        pix(1, 0, 0, GREEN, "green at origin");
        pix(1, 3, 3, GREEN, "green br");
        pix(1, 4, 0, BG,    "green right");
        pix(1, 0, 4, exp_rgb(1, 0, 4, 1'b1), "green below");

        // Asynchronous reset mid-line.
        pix(1, 5, 3, BG, "pre-reset pixel");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst rgb", {r_a[1], g_a[1], b_a[1]}, 0);
        chk("async rst de", ode_a[1], 0);
        chk("async rst bounce", bc_a[1], 0);
        chk("async rst bounce dut0", bc_a[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pix(1, 0, 0, WHITE, "post-reset origin");
        pix(1, 4, 4, BG,    "post-reset outside");
        pix(0, 0, 0, WHITE, "post-reset dut0 origin");
        pix(0, 64, 64, BG,  "post-reset dut0 outside");

        // Every frame bounces on the 8x8 screen: drive it to the wrap point.
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            sx_a[2] = 11'd0; sy_a[2] = 11'd8; men_a[2] = 1'b1;
            de_a[2] = 1'b0; hs_a[2] = 1'b0; vs_a[2] = 1'b1;
            model_tick(2);
        end
        @(posedge clk);
        #1;
        chk("bounce 65535", bc_a[2], 65535);
        pix(2, 4, 4, YELLOW, "yellow before wrap");
        pix(2, 3, 3, BG,     "outside before wrap");
        tick(2, 1'b1);
        chk("bounce wrapped", bc_a[2], 0);
        pix(2, 0, 0, WHITE, "white after wrap");
        pix(2, 3, 3, WHITE, "white br after wrap");
        pix(2, 4, 4, BG,    "outside after wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
